// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } if_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF   = 32'd4;

  // One fetched instruction together with the PC it came from
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_entry_t;

  // Instruction memory is word addressed; the low two bits never matter
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid.sv
// One-entry skid buffer holding an {instr, pc} pair while decode stalls.
module if_skid
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  logic      unload_i,
  input  logic      flush_i,
  input  if_entry_t din_i,
  output logic      full_o,
  output if_entry_t dout_o
);

  logic      full_q, full_d;
  if_entry_t data_q, data_d;

  // Flush/unload empty the entry (data reads as NOP); load fills it
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush_i || unload_i) begin
      full_d       = 1'b0;
      data_d.instr = NOP_INSTR;
      data_d.pc    = '0;
    end else if (load_i) begin
      full_d = 1'b1;
      data_d = din_i;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q       <= 1'b0;
      data_q.instr <= NOP_INSTR;
      data_q.pc    <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign dout_o = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding imem fetch, PC next-value
// generation and a registered valid/ready output backed by a skid entry.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] PC_STEP   = PC_STEP_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_ena,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  if_state_e   state_q, state_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        vld_q, vld_d;
  if_entry_t   out_q, out_d;

  logic        out_free;
  logic        ack_fetch;
  logic        skid_load, skid_unload, skid_full;
  logic [31:0] fetch_addr;
  if_entry_t   fetch_entry, skid_dout;

  assign fetch_addr        = align_word(pc);
  assign fetch_entry.instr = imem_rdata;
  assign fetch_entry.pc    = pc;
  assign out_free          = !vld_q || id_ready;
  // A fetch completes only in FETCH and only if no redirect kills it
  assign ack_fetch         = (state_q == ST_FETCH) && imem_ack && !br_taken;
  assign skid_load         = ack_fetch && !out_free;
  assign skid_unload       = (state_q == ST_HOLD) && id_ready && !br_taken;

  if_skid #(.NOP_INSTR(NOP_INSTR)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (br_taken),
    .din_i    (fetch_entry),
    .full_o   (skid_full),
    .dout_o   (skid_dout)
  );

  // FSM state and the address of an abandoned in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // Next state; redirect wins over every other event
  always_comb begin
    state_d     = state_q;
    drop_addr_d = drop_addr_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (br_taken) begin
          if (!imem_ack) begin
            // request still in flight: must wait its ack out at the old address
            state_d     = ST_DROP;
            drop_addr_d = fetch_addr;
          end
        end else if (imem_ack && !out_free) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (br_taken || id_ready) state_d = ST_FETCH;
      end
      ST_DROP: begin
        // a further redirect keeps the original drop_addr
        if (!br_taken && imem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory request and PC-register controls, combinational from state/inputs
  always_comb begin
    imem_req  = (state_q == ST_FETCH) || (state_q == ST_DROP);
    imem_addr = (state_q == ST_DROP) ? drop_addr_q : fetch_addr;
    pc_ena    = 1'b0;
    next_pc   = pc;
    if (br_taken) begin
      pc_ena  = 1'b1;
      next_pc = align_word(br_target);
    end else if (ack_fetch) begin
      pc_ena  = 1'b1;
      next_pc = pc + PC_STEP;
    end
  end

  // Output register: load from memory or skid, drain on accept, clear on redirect
  always_comb begin
    vld_d = vld_q;
    out_d = out_q;
    if (br_taken) begin
      vld_d       = 1'b0;
      out_d.instr = NOP_INSTR;
    end else if (ack_fetch && out_free) begin
      vld_d = 1'b1;
      out_d = fetch_entry;
    end else if (skid_unload && skid_full) begin
      vld_d = 1'b1;
      out_d = skid_dout;
    end else if (vld_q && id_ready) begin
      vld_d       = 1'b0;
      out_d.instr = NOP_INSTR;
    end
  end

  // Output register storage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= 1'b0;
      out_q.instr <= NOP_INSTR;
      out_q.pc    <= '0;
    end else begin
      vld_q <= vld_d;
      out_q <= out_d;
    end
  end

  assign if_valid = vld_q;
  assign if_instr = out_q.instr;
  assign if_pc    = out_q.pc;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: the bench models the PC register, drives
// imem/decode/redirect vectors, and a monitor checks every decode transfer
// against a queue of expected {instr, pc} pairs.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pc_ena;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .next_pc    (next_pc),
    .pc_ena     (pc_ena),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: the PC register takes next_pc at the edge where pc_ena is high
  task automatic cyc();
    logic        e;
    logic [31:0] n;
    e = pc_ena;
    n = next_pc;
    @(posedge clk);
    #1;
    if (rst) pc = 32'h0;
    else if (e) pc = n;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] p);
    sb.push_back({instr, p});
  endtask

  // Monitor: every accepted transfer to decode must match the queue head
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && if_valid && id_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got %h @ %h want none", if_instr, if_pc);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", if_instr, e[63:32]);
          chk("sb_pc", if_pc, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    br_taken = 1'b0; br_target = 32'h0; id_ready = 1'b1;
    @(negedge clk);
    cyc();
    #1;
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_pcena", {31'h0, pc_ena}, 32'h0);
    chk("rst_nextpc", next_pc, pc);
    rst = 1'b0; #1;
    chk("idle_req", {31'h0, imem_req}, 32'h0);
    cyc();
    #1;
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    // back-to-back acks, decode always ready
    imem_ack = 1'b1; imem_rdata = 32'h2008_0001; push(32'h2008_0001, 32'h0); #1;
    chk("a_pcena", {31'h0, pc_ena}, 32'h1);
    chk("a_next", next_pc, 32'h4);
    cyc();
    imem_rdata = 32'h2009_0002; push(32'h2009_0002, 32'h4); #1;
    chk("b_valid", {31'h0, if_valid}, 32'h1);
    chk("b_ifpc", if_pc, 32'h0);
    chk("b_pcena", {31'h0, pc_ena}, 32'h1);
    chk("b_next", next_pc, 32'h8);
    cyc();

    // ack delayed three cycles at pc 8
    imem_ack = 1'b0; #1;
    chk("c_ifpc", if_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", {31'h0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_pcena", {31'h0, pc_ena}, 32'h0);
      cyc();
      #1;
    end
    imem_ack = 1'b1; imem_rdata = 32'h1111_0008; push(32'h1111_0008, 32'h8); #1;
    chk("f_pcena", {31'h0, pc_ena}, 32'h1);
    chk("f_next", next_pc, 32'hC);
    cyc();

    // decode stalls while the 0xC fetch returns -> HOLD
    id_ready = 1'b0; imem_rdata = 32'h2222_000C; push(32'h2222_000C, 32'hC); #1;
    chk("g_valid", {31'h0, if_valid}, 32'h1);
    chk("g_ifpc", if_pc, 32'h8);
    chk("g_pcena", {31'h0, pc_ena}, 32'h1);
    chk("g_next", next_pc, 32'h10);
    cyc();
    imem_ack = 1'b0; #1;
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_pcena", {31'h0, pc_ena}, 32'h0);
    chk("hold_ifpc", if_pc, 32'h8);
    cyc();
    id_ready = 1'b1; #1;
    chk("unhold_req", {31'h0, imem_req}, 32'h0);
    cyc();

    // redirect to 0x40 while the 0x10 request is unacked
    br_taken = 1'b1; br_target = 32'h40; #1;
    chk("j_ifpc", if_pc, 32'hC);
    chk("j_req", {31'h0, imem_req}, 32'h1);
    chk("j_addr", imem_addr, 32'h10);
    chk("j_pcena", {31'h0, pc_ena}, 32'h1);
    chk("j_next", next_pc, 32'h40);
    cyc();
    br_taken = 1'b0; #1;
    chk("drop_valid", {31'h0, if_valid}, 32'h0);
    chk("drop_req", {31'h0, imem_req}, 32'h1);
    chk("drop_addr", imem_addr, 32'h10);
    chk("drop_pcena", {31'h0, pc_ena}, 32'h0);
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("dack_addr", imem_addr, 32'h10);
    chk("dack_pcena", {31'h0, pc_ena}, 32'h0);
    cyc();
    imem_ack = 1'b0; #1;
    chk("m_valid", {31'h0, if_valid}, 32'h0);
    chk("m_instr", if_instr, 32'h0);
    chk("m_req", {31'h0, imem_req}, 32'h1);
    chk("m_addr", imem_addr, 32'h40);
    cyc();

    // redirect to 0x43 coincident with an ack
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0040; br_taken = 1'b1; br_target = 32'h43; #1;
    chk("n_pcena", {31'h0, pc_ena}, 32'h1);
    chk("n_next", next_pc, 32'h40);
    cyc();
    br_taken = 1'b0; imem_ack = 1'b0; #1;
    chk("o_valid", {31'h0, if_valid}, 32'h0);
    chk("o_instr", if_instr, 32'h0);
    chk("o_addr", imem_addr, 32'h40);
    cyc();

    // fill output and skid, then reset in HOLD (neither entry is accepted)
    imem_ack = 1'b1; imem_rdata = 32'h3333_0040; id_ready = 1'b0; #1;
    cyc();
    imem_rdata = 32'h4444_0044; #1;
    chk("q_next", next_pc, 32'h48);
    cyc();
    imem_ack = 1'b0; #1;
    chk("r_req", {31'h0, imem_req}, 32'h0);
    chk("r_valid", {31'h0, if_valid}, 32'h1);
    chk("r_ifpc", if_pc, 32'h40);
    rst = 1'b1;
    cyc();
    #1;
    chk("rst2_valid", {31'h0, if_valid}, 32'h0);
    chk("rst2_instr", if_instr, 32'h0);
    chk("rst2_pc", if_pc, 32'h0);
    chk("rst2_req", {31'h0, imem_req}, 32'h0);
    chk("rst2_pcena", {31'h0, pc_ena}, 32'h0);
    chk("rst2_nextpc", next_pc, 32'h0);
    rst = 1'b0; id_ready = 1'b1;
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'h5555_0000; push(32'h5555_0000, 32'h0); #1;
    chk("t_req", {31'h0, imem_req}, 32'h1);
    chk("t_addr", imem_addr, 32'h0);
    cyc();

    // redirect (with discarded ack) to the top word, then wrap to 0
    imem_rdata = 32'h7777_7777; br_taken = 1'b1; br_target = 32'hFFFF_FFFF; #1;
    chk("u_next", next_pc, 32'hFFFF_FFFC);
    cyc();
    br_taken = 1'b0; imem_rdata = 32'h6666_FFFC; push(32'h6666_FFFC, 32'hFFFF_FFFC); #1;
    chk("v_valid", {31'h0, if_valid}, 32'h0);
    chk("v_addr", imem_addr, 32'hFFFF_FFFC);
    chk("v_next", next_pc, 32'h0);
    cyc();
    imem_ack = 1'b0; #1;
    chk("w_ifpc", if_pc, 32'hFFFF_FFFC);
    cyc();
    cyc();
    chk("sb_empty", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
